// File: rtl/pcs_rx_link_ctrl.sv
// 10GBASE-R PCS receive link bring-up/monitor: sequences SERDES rx reset, qualifies lock/BER, keeps stats.
// Optional sequence-error counter is built when PCS_RX_LINK_CTRL_SEQ_ERR_CNT_EN is defined.
module pcs_rx_link_ctrl #(
   parameter int RESET_CYCLES  = 4,
   parameter int LOCK_TIMEOUT  = 1024,
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic                 rx_block_lock,
   input  logic                 rx_high_ber,
   input  logic                 rx_bad_block,
   input  logic                 rx_sequence_error,
   input  logic                 serdes_rx_reset_req,
   input  logic                 clear_counters,
   output logic                 serdes_rx_reset,
   output logic                 pcs_status,
   output logic [2:0]           link_state,
   output logic [CNT_WIDTH-1:0] errored_block_count,
   output logic [CNT_WIDTH-1:0] retry_count,
   output logic [CNT_WIDTH-1:0] link_drop_count,
   output logic [CNT_WIDTH-1:0] seq_error_count
);

   localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int SW   = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_RESET_SERDES = 3'd0,
      ST_WAIT_LOCK    = 3'd1,
      ST_WAIT_STABLE  = 3'd2,
      ST_LINK_UP      = 3'd3,
      ST_HIGH_BER     = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [SW-1:0]  stable_q, stable_d;
   logic           serdes_rst_q;
   logic           pcs_status_q;
   logic           retry_inc, drop_inc, err_inc;
   logic [CNT_WIDTH-1:0] err_cnt_q, retry_cnt_q, drop_cnt_q;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      stable_d  = stable_q;
      retry_inc = 1'b0;
      drop_inc  = 1'b0;
      // A reset request preempts every other transition outside RESET_SERDES.
      if (serdes_rx_reset_req && (state_q != ST_RESET_SERDES)) begin
         state_d  = ST_RESET_SERDES;
         timer_d  = '0;
         stable_d = '0;
         drop_inc = (state_q == ST_LINK_UP);
      end else begin
         case (state_q)
            ST_RESET_SERDES: begin
               if (timer_q == TW'(RESET_CYCLES - 1)) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (rx_block_lock) begin
                  state_d  = ST_WAIT_STABLE;
                  stable_d = '0;
               end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                  state_d   = ST_RESET_SERDES;
                  timer_d   = '0;
                  retry_inc = 1'b1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            ST_WAIT_STABLE: begin
               if (!rx_block_lock) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = '0;
               end else if (rx_high_ber) begin
                  stable_d = '0;
               end else if (stable_q == SW'(STABLE_CYCLES - 1)) begin
                  state_d  = ST_LINK_UP;
                  stable_d = '0;
               end else begin
                  stable_d = stable_q + 1'b1;
               end
            end
            ST_LINK_UP: begin
               if (!rx_block_lock) begin
                  state_d  = ST_WAIT_LOCK;
                  timer_d  = '0;
                  drop_inc = 1'b1;
               end else if (rx_high_ber) begin
                  state_d  = ST_HIGH_BER;
                  drop_inc = 1'b1;
               end
            end
            ST_HIGH_BER: begin
               if (!rx_block_lock) begin
                  state_d = ST_WAIT_LOCK;
                  timer_d = '0;
               end else if (!rx_high_ber) begin
                  state_d  = ST_WAIT_STABLE;
                  stable_d = '0;
               end
            end
            default: begin
               state_d  = ST_RESET_SERDES;
               timer_d  = '0;
               stable_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge rx_clk) begin
      if (!rx_rst) begin
         state_q      <= ST_RESET_SERDES;
         timer_q      <= '0;
         stable_q     <= '0;
         serdes_rst_q <= 1'b1;
         pcs_status_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         stable_q     <= stable_d;
         serdes_rst_q <= (state_d == ST_RESET_SERDES);
         pcs_status_q <= (state_d == ST_LINK_UP);
      end
   end

   assign err_inc = rx_bad_block && ((state_q == ST_LINK_UP) || (state_q == ST_HIGH_BER));

   always_ff @(posedge rx_clk) begin
      if (!rx_rst || clear_counters) begin
         err_cnt_q   <= '0;
         retry_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         err_cnt_q   <= sat_inc(err_cnt_q, err_inc);
         retry_cnt_q <= sat_inc(retry_cnt_q, retry_inc);
         drop_cnt_q  <= sat_inc(drop_cnt_q, drop_inc);
      end
   end

`ifdef PCS_RX_LINK_CTRL_SEQ_ERR_CNT_EN
   logic [CNT_WIDTH-1:0] seq_cnt_q;
   logic                 seq_inc;

   assign seq_inc = rx_sequence_error && ((state_q == ST_LINK_UP) || (state_q == ST_HIGH_BER));

   always_ff @(posedge rx_clk) begin
      if (!rx_rst || clear_counters) begin
         seq_cnt_q <= '0;
      end else begin
         seq_cnt_q <= sat_inc(seq_cnt_q, seq_inc);
      end
   end

   assign seq_error_count = seq_cnt_q;
`else
   logic seq_err_unused;
   assign seq_err_unused  = rx_sequence_error;
   assign seq_error_count = '0;
`endif

   assign serdes_rx_reset     = serdes_rst_q;
   assign pcs_status          = pcs_status_q;
   assign link_state          = state_q;
   assign errored_block_count = err_cnt_q;
   assign retry_count         = retry_cnt_q;
   assign link_drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Self-checking bench for pcs_rx_link_ctrl: directed bring-up scenarios plus randomized traffic
// compared every cycle against a behavioural model of the link rules.
module tb_pcs_rx_link_ctrl;

   localparam int RC   = 4;
   localparam int LT   = 1024;
   localparam int SC   = 16;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, lock, ber, bad, seqe, req, clr;
   logic serdes, pcs;
   logic [2:0] link_state;
   logic [CW-1:0] err_cnt, retry_cnt, drop_cnt, seq_cnt;

   pcs_rx_link_ctrl #(
      .RESET_CYCLES (RC),
      .LOCK_TIMEOUT (LT),
      .STABLE_CYCLES(SC),
      .CNT_WIDTH    (CW)
   ) u_dut (
      .rx_clk             (clk),
      .rx_rst             (rst),
      .rx_block_lock      (lock),
      .rx_high_ber        (ber),
      .rx_bad_block       (bad),
      .rx_sequence_error  (seqe),
      .serdes_rx_reset_req(req),
      .clear_counters     (clr),
      .serdes_rx_reset    (serdes),
      .pcs_status         (pcs),
      .link_state         (link_state),
      .errored_block_count(err_cnt),
      .retry_count        (retry_cnt),
      .link_drop_count    (drop_cnt),
      .seq_error_count    (seq_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: states 0..4 as plain ints; m_age counts cycles spent in the current reset/lock window.
   int m_st, m_age, m_good, m_err, m_retry, m_drop, m_seq;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_update();
      if (!rst) begin
         m_st = 0; m_age = 0; m_good = 0;
         m_err = 0; m_retry = 0; m_drop = 0; m_seq = 0;
      end else begin
         if (m_st == 3 || m_st == 4) begin
            if (bad) m_err = sat(m_err);
`ifdef PCS_RX_LINK_CTRL_SEQ_ERR_CNT_EN
            if (seqe) m_seq = sat(m_seq);
`endif
         end
         if (req && m_st != 0) begin
            if (m_st == 3) m_drop = sat(m_drop);
            m_st = 0; m_age = 0;
         end else begin
            case (m_st)
               0: begin
                  m_age++;
                  if (m_age == RC) begin m_st = 1; m_age = 0; end
               end
               1: begin
                  if (lock) begin m_st = 2; m_good = 0; end
                  else begin
                     m_age++;
                     if (m_age == LT) begin m_st = 0; m_age = 0; m_retry = sat(m_retry); end
                  end
               end
               2: begin
                  if (!lock) begin m_st = 1; m_age = 0; end
                  else if (ber) m_good = 0;
                  else begin
                     m_good++;
                     if (m_good == SC) m_st = 3;
                  end
               end
               3: begin
                  if (!lock) begin m_st = 1; m_age = 0; m_drop = sat(m_drop); end
                  else if (ber) begin m_st = 4; m_drop = sat(m_drop); end
               end
               default: begin
                  if (!lock) begin m_st = 1; m_age = 0; end
                  else if (!ber) begin m_st = 2; m_good = 0; end
               end
            endcase
         end
         if (clr) begin
            m_err = 0; m_retry = 0; m_drop = 0; m_seq = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("link_state", link_state, m_st);
      check("serdes_rx_reset", serdes, (m_st == 0) ? 1 : 0);
      check("pcs_status", pcs, (m_st == 3) ? 1 : 0);
      check("errored_block_count", err_cnt, m_err);
      check("retry_count", retry_cnt, m_retry);
      check("link_drop_count", drop_cnt, m_drop);
      check("seq_error_count", seq_cnt, m_seq);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_link_up();
      int n = 0;
      while (!pcs && n < 2000) begin
         step();
         n++;
      end
      check("wait_link_up", pcs, 1);
   endtask

   initial begin
      int n, hi, attempts, d0, e0;
      logic prev;
      rst = 1'b0; lock = 1'b0; ber = 1'b0; bad = 1'b0; seqe = 1'b0; req = 1'b0; clr = 1'b0;
      m_st = 0; m_age = 0; m_good = 0; m_err = 0; m_retry = 0; m_drop = 0; m_seq = 0;

      repeat (3) step();
      check("reset_link_state", link_state, 0);
      check("reset_serdes", serdes, 1);
      check("reset_pcs", pcs, 0);
      check("reset_err_cnt", err_cnt, 0);
      $display("[tb] reset applied: link_state=%0d serdes=%0d", link_state, serdes);

      // Bring-up: reset window length, then lock-to-link latency
      rst = 1'b1;
      n = serdes ? 1 : 0;
      while (n < 50) begin
         step();
         if (!serdes) break;
         n++;
      end
      check("serdes_high_cycles", n, RC);
      repeat (6) step();
      lock = 1'b1;
      step();
      n = 0;
      while (!pcs && n < 100) begin
         step();
         n++;
      end
      check("lock_to_link_up", n, SC);
      check("bringup_state", link_state, 3);
      $display("[tb] bring-up: serdes window ok, link up after %0d cycles", n);

      // Lock timeout: two reset attempts within 2100 lock-less cycles
      lock = 1'b0;
      hi = 0; attempts = 0; prev = serdes;
      for (int i = 0; i < 2100; i++) begin
         step();
         if (pcs) hi++;
         if (serdes && !prev) attempts++;
         prev = serdes;
      end
      check("timeout_pcs_high", hi, 0);
      check("timeout_attempts", attempts, 2);
      check("timeout_retry_count", retry_cnt, 2);
      $display("[tb] lock timeout: attempts=%0d retry_count=%0d", attempts, retry_cnt);

      // High BER while up
      lock = 1'b1;
      wait_link_up();
      d0 = m_drop;
      ber = 1'b1;
      step();
      check("hiber_state", link_state, 4);
      check("hiber_pcs", pcs, 0);
      check("hiber_drop", drop_cnt, d0 + 1);
      repeat (49) step();
      check("hiber_hold_state", link_state, 4);
      ber = 1'b0;
      step();
      check("hiber_exit_state", link_state, 2);
      n = 0;
      while (!pcs && n < 100) begin
         step();
         n++;
      end
      check("hiber_recover_cycles", n, SC);
      $display("[tb] high BER pulse: drop_count=%0d recovered after %0d stable cycles", drop_cnt, n);

      // Simultaneous reset request, lock loss and bad block in LINK_UP
      d0 = m_drop; e0 = m_err;
      req = 1'b1; lock = 1'b0; bad = 1'b1;
      step();
      req = 1'b0; lock = 1'b1; bad = 1'b0;
      check("simul_state", link_state, 0);
      check("simul_drop", drop_cnt, d0 + 1);
      check("simul_err", err_cnt, e0 + 1);
      $display("[tb] simultaneous events: state=%0d drop=%0d err=%0d", link_state, drop_cnt, err_cnt);

      // Saturation then clear
      wait_link_up();
      bad = 1'b1;
      repeat (20) step();
      check("sat_err_count", err_cnt, CMAX);
      clr = 1'b1;
      step();
      clr = 1'b0; bad = 1'b0;
      check("clear_err_count", err_cnt, 0);
      check("clear_drop_count", drop_cnt, 0);
      check("clear_keeps_link", link_state, 3);
      $display("[tb] saturation/clear: err_count cleared to %0d", err_cnt);

      // Optional sequence-error counter
      for (int i = 0; i < 3; i++) begin
         seqe = 1'b1;
         step();
         seqe = 1'b0;
         step();
      end
`ifdef PCS_RX_LINK_CTRL_SEQ_ERR_CNT_EN
      check("seq_err_count", seq_cnt, 3);
`else
      check("seq_err_count", seq_cnt, 0);
`endif
      $display("[tb] sequence errors: seq_error_count=%0d", seq_cnt);

      // Randomized traffic
      for (int i = 0; i < 6000; i++) begin
         rst  = ($urandom_range(0, 499) != 0);
         lock = lock ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 19) == 0);
         ber  = ($urandom_range(0, 199) == 0) ? 1'b1 : (ber && ($urandom_range(0, 9) != 0));
         req  = ($urandom_range(0, 399) == 0);
         clr  = ($urandom_range(0, 299) == 0);
         bad  = ($urandom_range(0, 3) == 0);
         seqe = ($urandom_range(0, 4) == 0);
         step();
      end
      $display("[tb] random traffic: 6000 cycles, final state=%0d", link_state);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pcs_rx_link_ctrl.md
Name: pcs_rx_link_ctrl

Overview:
- Receive-side link bring-up and monitor controller for the 10GBASE-R PCS.
- Sits beside the PCS receive path and sequences the SERDES receive reset.
- Waits for block lock and for bit-error-rate (BER) to settle, then qualifies the link and drives pcs_status.
- Keeps saturating statistics counters for errored blocks, retries and link drops.

Parameters:
- RESET_CYCLES, 4: cycles serdes_rx_reset is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 1024: cycles allowed in WAIT_LOCK before a new reset attempt (>=2).
- STABLE_CYCLES, 16: consecutive cycles of rx_block_lock=1 and rx_high_ber=0 required before LINK_UP (>=1).
- CNT_WIDTH, 16: width of every statistics counter.

Ports:
- rx_clk, input, 1: sole clock.
- rx_rst, input, 1: synchronous, active-low reset.
- rx_block_lock, input, 1: block lock from the PCS receive path.
- rx_high_ber, input, 1: high-BER flag from the BER monitor.
- rx_bad_block, input, 1: one errored block decoded this cycle.
- rx_sequence_error, input, 1: sequence error this cycle.
- serdes_rx_reset_req, input, 1: PCS request to reset the SERDES receiver.
- clear_counters, input, 1: synchronous clear of all statistics counters.
- serdes_rx_reset, output, 1: reset to the SERDES receiver.
- pcs_status, output, 1: link qualified (high only in LINK_UP).
- link_state, output, 3: encoded FSM state.
- errored_block_count, output, CNT_WIDTH: saturating count of errored blocks.
- retry_count, output, CNT_WIDTH: saturating count of lock timeouts.
- link_drop_count, output, CNT_WIDTH: saturating count of LINK_UP exits.
- seq_error_count, output, CNT_WIDTH: saturating count of sequence errors (see Optional Feature).

Behaviour:
- Reset (rx_rst=0 at a rising edge): state=RESET_SERDES, timers=0, all counters=0, pcs_status=0. serdes_rx_reset=1 while rx_rst is low. Reset mid-operation aborts any state immediately.
- All outputs are registered. pcs_status=1 exactly in the cycles where link_state=LINK_UP.
- RESET_SERDES (0): serdes_rx_reset=1 for RESET_CYCLES cycles, then go to WAIT_LOCK with serdes_rx_reset=0 and timer cleared.
- WAIT_LOCK (1): the timer increments each cycle.
  - rx_block_lock=1 -> WAIT_STABLE.
  - Otherwise, when timer=LOCK_TIMEOUT-1 -> RESET_SERDES and retry_count+1.
  - If lock and timeout occur in the same cycle, lock wins.
- WAIT_STABLE (2): the stable counter increments while rx_block_lock=1 and rx_high_ber=0.
  - rx_high_ber=1 -> stable counter reset to 0; state unchanged.
  - rx_block_lock=0 -> WAIT_LOCK.
  - Counter reaches STABLE_CYCLES -> LINK_UP. pcs_status rises on the edge after the STABLE_CYCLES-th good cycle.
- LINK_UP (3):
  - rx_block_lock=0 -> WAIT_LOCK and link_drop_count+1.
  - Else rx_high_ber=1 -> HIGH_BER and link_drop_count+1.
  - If both occur in the same cycle, lock loss wins and the drop is counted once.
- HIGH_BER (4):
  - rx_block_lock=0 -> WAIT_LOCK.
  - rx_high_ber=0 -> WAIT_STABLE with the stable counter cleared.
- Global: serdes_rx_reset_req=1 in any state other than RESET_SERDES -> RESET_SERDES. This has highest priority over every other transition.
  - If taken from LINK_UP, link_drop_count+1.
  - serdes_rx_reset_req is ignored while already in RESET_SERDES; the reset window is not extended.
- errored_block_count: +1 on rx_bad_block=1, only in LINK_UP or HIGH_BER.
- Counter rules, all counters:
  - Saturate at 2^CNT_WIDTH-1 with no wrap.
  - clear_counters=1 zeroes all counters and wins over a simultaneous increment.
  - FSM operation is unaffected by clear_counters.
- Encodings 5-7 are unreachable; if ever decoded, go to RESET_SERDES.

Optional Feature:
- Macro: PCS_RX_LINK_CTRL_SEQ_ERR_CNT_EN.
- Defined: seq_error_count increments on rx_sequence_error=1 in LINK_UP or HIGH_BER, with the same saturation and clear rules as the other counters.
- Undefined: the counter logic is not built, seq_error_count is tied to 0, and rx_sequence_error is ignored.

Test Plan:
- Bring-up: release rx_rst and raise rx_block_lock 10 cycles later with rx_high_ber=0. Expect serdes_rx_reset high for exactly 4 cycles, then pcs_status=1 exactly 16 cycles after lock is seen, and link_state=3.
- Lock timeout: keep rx_block_lock=0 for 2100 cycles. Expect 2 reset attempts, retry_count=2, and pcs_status=0 throughout.
- High BER in LINK_UP: pulse rx_high_ber for 50 cycles. Expect link_state=4, pcs_status=0, link_drop_count=1; after the pulse, return to LINK_UP 16 cycles after rx_high_ber falls.
- Simultaneous events in LINK_UP: raise serdes_rx_reset_req, drop lock and assert rx_bad_block in the same cycle. Expect state RESET_SERDES, link_drop_count+1 once, errored_block_count+1.
- Saturation and clear: with CNT_WIDTH=4, drive 20 rx_bad_block cycles in LINK_UP. Expect errored_block_count=15. Then assert clear_counters together with rx_bad_block; expect count=0.
- Macro check: drive 3 rx_sequence_error pulses in LINK_UP. Expect seq_error_count=3 with PCS_RX_LINK_CTRL_SEQ_ERR_CNT_EN defined, 0 without it.
